// File: rtl/feature_scaler_pkg.sv
// feature_scaler_pkg: shared load-FSM states, header byte, identity gain and saturation bounds.
package feature_scaler_pkg;

    typedef enum logic [2:0] {
        CFG_IDLE,
        CFG_MEAN_HI,
        CFG_MEAN_LO,
        CFG_GAIN_HI,
        CFG_GAIN_LO,
        CFG_COMMIT
    } cfg_state_e;

    localparam logic [7:0] CFG_HEADER = 8'hA5;

    function automatic logic signed [15:0] identity_gain(input int frac_bits);
        return 16'(1 << frac_bits);
    endfunction

    localparam logic signed [15:0] IDENTITY_GAIN = identity_gain(8);
    localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [15:0] SAT_MIN = 16'sh8000;

endpackage

// File: rtl/feature_scaler_if.sv
// feature_scaler_if: raw feature stream in, parameter byte stream in, scaled feature stream out.
interface feature_scaler_if;
    logic signed [15:0] raw_data_in;
    logic               raw_valid_in;
    logic               raw_last_in;
    logic [7:0]         cfg_data_in;
    logic               cfg_valid_in;
    logic signed [15:0] feature_data_out;
    logic               feature_valid_out;
    logic               feature_last_out;

    modport slave (
        input  raw_data_in, raw_valid_in, raw_last_in, cfg_data_in, cfg_valid_in,
        output feature_data_out, feature_valid_out, feature_last_out
    );

    modport master (
        output raw_data_in, raw_valid_in, raw_last_in, cfg_data_in, cfg_valid_in,
        input  feature_data_out, feature_valid_out, feature_last_out
    );
endinterface

// File: rtl/feature_scaler_mac_sat.sv
// scaler_mac_sat: registered stage computing sat16((diff * gain) >>> FRAC_BITS), with a saturated flag.
module scaler_mac_sat
    import feature_scaler_pkg::*;
#(
    parameter int FRAC_BITS = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic signed [16:0] diff_i,
    input  logic signed [15:0] gain_i,
    input  logic               valid_i,
    input  logic               last_i,
    input  logic               ovf_i,
    output logic signed [15:0] data_o,
    output logic               valid_o,
    output logic               last_o,
    output logic               ovf_o,
    output logic               sat_o
);

    logic signed [32:0] prod;
    logic signed [32:0] shifted;
    logic               hi;
    logic               lo;
    logic signed [15:0] data_q;
    logic               valid_q;
    logic               last_q;
    logic               ovf_q;
    logic               sat_q;

    always_comb begin
        prod    = 33'(diff_i) * 33'(gain_i);
        shifted = prod >>> FRAC_BITS;
        hi      = shifted > 33'(SAT_MAX);
        lo      = shifted < 33'(SAT_MIN);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            data_q  <= hi ? SAT_MAX : lo ? SAT_MIN : shifted[15:0];
            valid_q <= valid_i;
            last_q  <= last_i;
            ovf_q   <= ovf_i;
            sat_q   <= valid_i && (hi || lo);
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign ovf_o   = ovf_q;
    assign sat_o   = sat_q;

endmodule

// File: rtl/feature_scaler.sv
// feature_scaler: per-feature y = sat16(((x - mean[i]) * gain[i]) >>> GAIN_FRAC_BITS), byte-loaded tables.
// FEATURE_SCALER_SAT_COUNT_EN adds sat_count_out, a count of saturated output beats cleared on commit.
module feature_scaler
    import feature_scaler_pkg::*;
#(
    parameter int NUM_FEATURES   = 16,
    parameter int GAIN_FRAC_BITS = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    feature_scaler_if.slave  bus,
    output logic             params_loaded_out,
    output logic             overflow_out
`ifdef FEATURE_SCALER_SAT_COUNT_EN
   ,output logic [15:0]      sat_count_out
`endif
);

    localparam int IDX_W = NUM_FEATURES > 1 ? $clog2(NUM_FEATURES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEATURES - 1);
    localparam logic signed [15:0] ID_GAIN = identity_gain(GAIN_FRAC_BITS);

    logic signed [15:0] mean_q    [NUM_FEATURES];
    logic signed [15:0] gain_q    [NUM_FEATURES];
    logic signed [15:0] sh_mean_q [NUM_FEATURES];
    logic signed [15:0] sh_gain_q [NUM_FEATURES];
    cfg_state_e         state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [7:0]         hi_q;
    logic               mean_we, gain_we, commit;
    logic               params_q;
    logic [IDX_W-1:0]   idx_q, s1_idx_q;
    logic               frame_q;
    logic signed [16:0] diff_q;
    logic               s1_valid_q, s1_last_q, s1_ovf_q;
    logic               wrap;
    logic signed [15:0] y;
    logic               y_valid, y_last;

    assign wrap = bus.raw_valid_in && !bus.raw_last_in && idx_q == LAST_IDX;

    // Commit waits for a gap between vectors so a vector never mixes parameter sets.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mean_we = 1'b0;
        gain_we = 1'b0;
        commit  = 1'b0;
        if (state_q == CFG_COMMIT) begin
            if (!frame_q && !bus.raw_valid_in) begin
                commit  = 1'b1;
                state_d = CFG_IDLE;
                k_d     = '0;
            end
        end else if (bus.cfg_valid_in) begin
            case (state_q)
                CFG_IDLE:    state_d = bus.cfg_data_in == CFG_HEADER ? CFG_MEAN_HI : CFG_IDLE;
                CFG_MEAN_HI: state_d = CFG_MEAN_LO;
                CFG_MEAN_LO: begin
                    mean_we = 1'b1;
                    state_d = CFG_GAIN_HI;
                end
                CFG_GAIN_HI: state_d = CFG_GAIN_LO;
                CFG_GAIN_LO: begin
                    gain_we = 1'b1;
                    k_d     = k_q == LAST_IDX ? '0 : k_q + 1'b1;
                    state_d = k_q == LAST_IDX ? CFG_COMMIT : CFG_MEAN_HI;
                end
                default:     state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= CFG_IDLE;
            k_q      <= '0;
            hi_q     <= '0;
            params_q <= 1'b0;
            for (int i = 0; i < NUM_FEATURES; i++) begin
                mean_q[i]    <= '0;
                gain_q[i]    <= ID_GAIN;
                sh_mean_q[i] <= '0;
                sh_gain_q[i] <= ID_GAIN;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            if (bus.cfg_valid_in && (state_q == CFG_MEAN_HI || state_q == CFG_GAIN_HI))
                hi_q <= bus.cfg_data_in;
            if (mean_we)
                sh_mean_q[k_q] <= {hi_q, bus.cfg_data_in};
            if (gain_we)
                sh_gain_q[k_q] <= {hi_q, bus.cfg_data_in};
            if (commit) begin
                mean_q   <= sh_mean_q;
                gain_q   <= sh_gain_q;
                params_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idx_q      <= '0;
            frame_q    <= 1'b0;
            diff_q     <= '0;
            s1_idx_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_ovf_q   <= 1'b0;
        end else begin
            if (bus.raw_valid_in) begin
                idx_q   <= (bus.raw_last_in || wrap) ? '0 : idx_q + 1'b1;
                frame_q <= !bus.raw_last_in;
            end
            diff_q     <= 17'(bus.raw_data_in) - 17'(mean_q[idx_q]);
            s1_idx_q   <= idx_q;
            s1_valid_q <= bus.raw_valid_in;
            s1_last_q  <= bus.raw_valid_in && bus.raw_last_in;
            s1_ovf_q   <= wrap;
        end
    end

`ifdef FEATURE_SCALER_SAT_COUNT_EN
    logic        sat;
    logic [15:0] sat_cnt_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            sat_cnt_q <= '0;
        else if (commit)
            sat_cnt_q <= '0;
        else if (sat && sat_cnt_q != 16'hFFFF)
            sat_cnt_q <= sat_cnt_q + 16'd1;
    end

    assign sat_count_out = sat_cnt_q;
`else
    logic sat_unused;
`endif

    scaler_mac_sat #(.FRAC_BITS(GAIN_FRAC_BITS)) u_mac (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .diff_i  (diff_q),
        .gain_i  (gain_q[s1_idx_q]),
        .valid_i (s1_valid_q),
        .last_i  (s1_last_q),
        .ovf_i   (s1_ovf_q),
        .data_o  (y),
        .valid_o (y_valid),
        .last_o  (y_last),
        .ovf_o   (overflow_out),
`ifdef FEATURE_SCALER_SAT_COUNT_EN
        .sat_o   (sat)
`else
        .sat_o   (sat_unused)
`endif
    );

    assign bus.feature_data_out  = y;
    assign bus.feature_valid_out = y_valid;
    assign bus.feature_last_out  = y_last;
    assign params_loaded_out     = params_q;

endmodule

// File: tb/tb_feature_scaler.sv
// tb_feature_scaler: directed vectors with hand-computed expectations for feature_scaler.
module tb_feature_scaler;

    localparam int NF = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic params_loaded;
    logic overflow;
`ifdef FEATURE_SCALER_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    always #5 clk = ~clk;

    feature_scaler_if ifc();

    feature_scaler #(.NUM_FEATURES(NF), .GAIN_FRAC_BITS(8)) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .bus               (ifc),
        .params_loaded_out (params_loaded),
        .overflow_out      (overflow)
`ifdef FEATURE_SCALER_SAT_COUNT_EN
       ,.sat_count_out     (sat_count)
`endif
    );

    typedef struct {
        logic signed [15:0] d;
        logic               l;
        logic               o;
        int                 c;
    } out_t;

    out_t oq[$];
    int   iq[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk)
        if (ifc.feature_valid_out === 1'b1)
            oq.push_back('{ifc.feature_data_out, ifc.feature_last_out, overflow, cyc});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        ifc.raw_valid_in = 1'b0;
        ifc.raw_last_in  = 1'b0;
        ifc.cfg_valid_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic signed [15:0] x, input logic l);
        ifc.raw_data_in  = x;
        ifc.raw_valid_in = 1'b1;
        ifc.raw_last_in  = l;
        @(negedge clk);
        iq.push_back(cyc);
    endtask

    task automatic cfg(input logic [7:0] b);
        ifc.cfg_data_in  = b;
        ifc.cfg_valid_in = 1'b1;
        @(negedge clk);
        ifc.cfg_valid_in = 1'b0;
    endtask

    task automatic load(input logic [15:0] m, input logic [15:0] g);
        cfg(8'hA5);
        for (int k = 0; k < NF; k++) begin
            cfg(m[15:8]);
            cfg(m[7:0]);
            cfg(g[15:8]);
            cfg(g[7:0]);
        end
        idle(3);
    endtask

    task automatic clr();
        oq.delete();
        iq.delete();
    endtask

    task automatic exp_out(input int i, input logic signed [15:0] d, input logic l, input logic o);
        if (i < oq.size() && i < iq.size()) begin
            chk($sformatf("data[%0d]", i), oq[i].d, d);
            chk($sformatf("last[%0d]", i), oq[i].l, l);
            chk($sformatf("ovf[%0d]", i), oq[i].o, o);
            chk($sformatf("latency[%0d]", i), oq[i].c, iq[i] + 1);
        end
    endtask

    initial begin
        ifc.raw_data_in  = '0;
        ifc.raw_valid_in = 1'b0;
        ifc.raw_last_in  = 1'b0;
        ifc.cfg_data_in  = '0;
        ifc.cfg_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", ifc.feature_valid_out, 1'b0);
        chk("rst_last", ifc.feature_last_out, 1'b0);
        chk("rst_data", ifc.feature_data_out, 16'h0000);
        chk("rst_params", params_loaded, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
`ifdef FEATURE_SCALER_SAT_COUNT_EN
        chk("rst_satcnt", sat_count, 16'h0000);
`endif
        rst_n = 1'b1;
        idle(2);

        // identity tables after reset
        clr();
        for (int i = 0; i < NF; i++) send(16'(i), i == NF - 1);
        idle(4);
        chk("id_count", oq.size(), NF);
        for (int i = 0; i < NF; i++) exp_out(i, 16'(i), i == NF - 1, 1'b0);

        // mean 100, gain 2.0: 150 -> 100, 36 -> -128
        load(16'd100, 16'h0200);
        chk("load_params", params_loaded, 1'b1);
        clr();
        send(16'sd150, 1'b0);
        send(16'sd36, 1'b1);
        idle(4);
        chk("load_count", oq.size(), 2);
        exp_out(0, 16'sd100, 1'b0, 1'b0);
        exp_out(1, -16'sd128, 1'b1, 1'b0);

        // gain 0.5: -3 -> floor(-1.5) = -2, 3 -> 1
        load(16'd0, 16'h0080);
        clr();
        send(-16'sd3, 1'b0);
        send(16'sd3, 1'b1);
        idle(4);
        chk("rnd_count", oq.size(), 2);
        exp_out(0, -16'sd2, 1'b0, 1'b0);
        exp_out(1, 16'sd1, 1'b1, 1'b0);

        // positive saturation
        load(16'h8000, 16'h0100);
`ifdef FEATURE_SCALER_SAT_COUNT_EN
        chk("satcnt_commit0", sat_count, 16'h0000);
`endif
        clr();
        send(16'sh7FFF, 1'b1);
        idle(4);
        chk("satp_count", oq.size(), 1);
        exp_out(0, 16'sh7FFF, 1'b1, 1'b0);
`ifdef FEATURE_SCALER_SAT_COUNT_EN
        chk("satcnt_pos", sat_count, 16'h0001);
`endif

        // negative saturation followed by an in-range beat
        load(16'h7FFF, 16'h0100);
`ifdef FEATURE_SCALER_SAT_COUNT_EN
        chk("satcnt_commit1", sat_count, 16'h0000);
`endif
        clr();
        send(16'sh8000, 1'b0);
        send(16'sd0, 1'b1);
        idle(4);
        chk("satn_count", oq.size(), 2);
        exp_out(0, 16'sh8000, 1'b0, 1'b0);
        exp_out(1, -16'sd32767, 1'b1, 1'b0);
`ifdef FEATURE_SCALER_SAT_COUNT_EN
        chk("satcnt_neg", sat_count, 16'h0001);
`endif

        // reset during a partial load restores identity tables
        cfg(8'hA5);
        cfg(8'h00);
        cfg(8'h05);
        cfg(8'h00);
        cfg(8'h07);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst_params", params_loaded, 1'b0);
        chk("midrst_valid", ifc.feature_valid_out, 1'b0);
        rst_n = 1'b1;
        idle(2);
        clr();
        send(16'sd7, 1'b1);
        idle(4);
        chk("midrst_count", oq.size(), 1);
        exp_out(0, 16'sd7, 1'b1, 1'b0);

        // load completes mid-vector: rest of vector keeps identity, next uses 2*(x-4)
        clr();
        for (int i = 0; i < 6; i++) send(16'(10 + i), 1'b0);
        idle(2);
        cfg(8'h00);
        cfg(8'h12);
        load(16'd4, 16'h0200);
        chk("defer_wait", params_loaded, 1'b0);
        for (int i = 6; i < NF; i++) send(16'(10 + i), i == NF - 1);
        chk("defer_hold", params_loaded, 1'b0);
        idle(3);
        chk("defer_commit", params_loaded, 1'b1);
        chk("defer_count", oq.size(), NF);
        for (int i = 0; i < NF; i++) exp_out(i, 16'(10 + i), i == NF - 1, 1'b0);
        clr();
        send(16'sd10, 1'b0);
        send(16'sd11, 1'b0);
        send(16'sd12, 1'b1);
        idle(4);
        chk("new_count", oq.size(), 3);
        exp_out(0, 16'sd12, 1'b0, 1'b0);
        exp_out(1, 16'sd14, 1'b0, 1'b0);
        exp_out(2, 16'sd16, 1'b1, 1'b0);

        // 18-beat vector without last: overflow on the 16th output only
        clr();
        for (int i = 0; i < 18; i++) send(16'sd10, 1'b0);
        idle(4);
        chk("ovf_count", oq.size(), 18);
        for (int i = 0; i < 18; i++) exp_out(i, 16'sd12, 1'b0, i == NF - 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/feature_scaler.md
Name: feature_scaler

Overview:
Per-feature affine normaliser directly upstream of the SVM classifier. Consumes the raw 16-bit feature-vector stream from feature extraction and applies y = sat16(((x - mean[i]) * gain[i]) >>> 8) per feature index i. It emits the stream in the same valid/last format the classifier consumes. Mean and gain tables are loaded as a byte stream from the BLE demux on a channel dedicated to this block.

Parameters:
NUM_FEATURES, 16, features per vector; table depth; index width is $clog2(NUM_FEATURES).
GAIN_FRAC_BITS, 8, fractional bits of gain (Q7.8 at default).

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous, active-low reset
raw_data_in  input  16  signed raw feature
raw_valid_in  input  1  raw feature valid
raw_last_in  input  1  last feature of vector
cfg_data_in  input  8  parameter byte from BLE demux
cfg_valid_in  input  1  parameter byte valid
feature_data_out  output  16  signed scaled feature
feature_valid_out  output  1  scaled feature valid
feature_last_out  output  1  last of vector
params_loaded_out  output  1  sticky; high once a load has committed
overflow_out  output  1  one-cycle pulse on vector longer than NUM_FEATURES

Behaviour:
- Reset (async assert, sync release): all outputs 0; active and shadow mean[] = 0; gain[] = 1<<GAIN_FRAC_BITS (identity); load FSM IDLE; feature index 0; frame_active 0.
- Datapath, 2-cycle latency, no backpressure. Input accepted on every raw_valid_in.
- S1 registers diff = x - mean[idx] (17-bit signed), idx, valid and last.
- S2 computes diff*gain[idx] (33-bit signed), then arithmetic shift right by GAIN_FRAC_BITS, then saturates to [-32768, 32767], and registers the outputs.
- valid/last are delayed in lockstep with data. Output valid is never high without input valid 2 cycles earlier.
- Index: idx resets to 0 after a beat with raw_last_in. Otherwise it increments on each valid beat.
- If idx == NUM_FEATURES-1 and the beat is not last, idx wraps to 0 and overflow_out pulses with that beat's S2 output. The data is still emitted.
- frame_active is set by a valid non-last beat and cleared by a valid last beat.
- Load FSM (on cfg_valid_in only):
  - IDLE: waits for header byte 0xA5. Other bytes are ignored.
  - MEAN_HI, MEAN_LO, GAIN_HI, GAIN_LO: big-endian, written to shadow[k]. k advances after GAIN_LO. After k == NUM_FEATURES-1, go to COMMIT.
  - COMMIT: no byte consumption. When frame_active == 0 and raw_valid_in == 0, copy shadow to active in one cycle, set params_loaded_out, and return to IDLE.
  - A vector in flight always finishes with its old parameters. Bytes arriving during COMMIT are dropped.
- Table reads use the active bank only. Shadow writes never affect the output.
- Reset mid-load discards the shadow contents and the active bank reverts to identity.

Optional Feature:
FEATURE_SCALER_SAT_COUNT_EN
- Defined: adds output sat_count_out [15:0]. It counts S2 beats where saturation altered the value. The counter saturates at 0xFFFF and clears on reset and on commit.
- Undefined: port and counter are absent; datapath behaviour is identical.

Decomposition:
- Package feature_scaler_pkg holds:
  - load-state enum {CFG_IDLE, CFG_MEAN_HI, CFG_MEAN_LO, CFG_GAIN_HI, CFG_GAIN_LO, CFG_COMMIT}
  - CFG_HEADER = 8'hA5
  - IDENTITY_GAIN
  - saturation bounds
- One sub-module, scaler_mac_sat: the S2 multiply/shift/saturate stage, registered, with a saturated flag output.

Test Plan:
- Identity after reset: vector 0..15 with last on 15 -> outputs 0..15, last on 15th output, 2 cycles after each input; overflow_out 0.
- Load: 0xA5, then mean=100 and gain=0x0200 for all features; then input 150 -> output 100.
- Negative rounding: mean=0, gain=0x0080, input -3 -> -2 (arithmetic shift floors).
- Saturation: mean=-32768, gain=0x0100, input 32767 -> 32767; input -32768 with mean=32767 -> -32768. With the macro defined, sat_count_out increments by exactly 1 each.
- Deferred commit: load completes after feature 5 of a vector -> features 6..15 use old params, next vector uses new ones; params_loaded_out rises between vectors.
- Robustness: bytes 0x00 and 0x12 before the header are ignored. An 18-beat vector with no last -> overflow_out pulses on the 16th beat's output. Reset asserted mid-load -> identity output and params_loaded_out 0.
